// File: rtl/key_debounce.sv
// Per-key 2-FF synchronizer, polarity normalisation and debounce FSM with press/release/glitch pulses.
// Latency: pin edge captured at posedge k -> out_key and pulse registered at posedge k+1+CNT_TH.
// No backpressure: pulses are one-cycle events and must be consumed in the cycle they appear.
module key_debounce #(
    parameter int IN_C_HZ        = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int NUM_KEYS       = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] in_key,
    output logic [NUM_KEYS-1:0] out_key,
    output logic [NUM_KEYS-1:0] out_press,
    output logic [NUM_KEYS-1:0] out_release,
    output logic [NUM_KEYS-1:0] out_glitch
);

    localparam int CNT_TH = DEBOUNCE_MS * (IN_C_HZ / 1000);
    localparam int CW     = $clog2(CNT_TH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_TH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    generate
        if (CNT_TH < 2 || NUM_KEYS < 1) begin : g_bad_cfg
            $error("key_debounce: CNT_TH must be >= 2 and NUM_KEYS >= 1");
        end
    endgenerate

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        logic          sync1;
        logic          sync2;
        logic          sync;
        state_t        state;
        logic [CW-1:0] cnt;
        logic          key_q;
        logic          press_q;
        logic          release_q;
        logic          glitch_q;

        // Normalised so that 1 always means pressed, whatever the board wiring.
        assign sync = sync2 ^ KEY_ACTIVE_LOW;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1     <= KEY_ACTIVE_LOW;
                sync2     <= KEY_ACTIVE_LOW;
                state     <= IDLE;
                cnt       <= '0;
                key_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                glitch_q  <= 1'b0;
            end else begin
                sync1     <= in_key[i];
                sync2     <= sync1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                glitch_q  <= 1'b0;
                case (state)
                    IDLE: begin
                        if (sync) begin
                            state <= CHK_PRESS;
                            cnt   <= CW'(1);
                        end
                    end
                    CHK_PRESS: begin
                        if (!sync) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            glitch_q <= 1'b1;
                        end else if (cnt == CNT_LAST) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            key_q   <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync) begin
                            state <= CHK_REL;
                            cnt   <= CW'(1);
                        end
                    end
                    CHK_REL: begin
                        if (sync) begin
                            state    <= PRESSED;
                            cnt      <= '0;
                            glitch_q <= 1'b1;
                        end else if (cnt == CNT_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            key_q     <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign out_key[i]     = key_q;
        assign out_press[i]   = press_q;
        assign out_release[i] = release_q;
        assign out_glitch[i]  = glitch_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_TH = 5, one active-low and one active-high instance.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_key = 4'hF;
    logic [3:0] out_key, out_press, out_release, out_glitch;
    logic [3:0] in_p = 4'h0;
    logic [3:0] key_p, press_p, release_p, glitch_p;

    int n_cmp = 0;
    int n_bad = 0;
    int n_press = 0, n_release = 0, n_glitch = 0;
    int n_press_p0 = 0, n_pulse_p_other = 0;

    always #5 clk = ~clk;

    key_debounce #(.IN_C_HZ(1000), .DEBOUNCE_MS(5), .NUM_KEYS(4), .KEY_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_key(in_key),
        .out_key(out_key), .out_press(out_press), .out_release(out_release), .out_glitch(out_glitch)
    );

    key_debounce #(.IN_C_HZ(1000), .DEBOUNCE_MS(5), .NUM_KEYS(4), .KEY_ACTIVE_LOW(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_key(in_p),
        .out_key(key_p), .out_press(press_p), .out_release(release_p), .out_glitch(glitch_p)
    );

    always @(negedge clk) begin
        n_press         += $countones(out_press);
        n_release       += $countones(out_release);
        n_glitch        += $countones(out_glitch);
        n_press_p0      += int'(press_p[0]);
        n_pulse_p_other += $countones(press_p[3:1]) + $countones(release_p)
                         + $countones(glitch_p);
        if ((out_press & out_release) != 4'h0) begin
            n_bad++;
            $display("FAIL press_and_release_same_cycle: got %0h expected 0", out_press & out_release);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_key", out_key, 4'h0);
        chk("rst_pulses", {out_press, out_release, out_glitch}, 12'h000);
        chk("rst_key_p", key_p, 4'h0);
        rst_n = 1'b1;
        tick(3);

        // Clean press on lane 0: capture at k, accept at k+6
        in_key[0] = 1'b0;
        tick(6);
        chk("s1_key_k5", out_key, 4'h0);
        chk("s1_press_k5", out_press, 4'h0);
        tick(1);
        chk("s1_key_k6", out_key, 4'h1);
        chk("s1_press_k6", out_press, 4'h1);
        tick(1);
        chk("s1_press_k7", out_press, 4'h0);
        chk("s1_key_k7", out_key, 4'h1);

        // Release bounce: high 2, low 1, then high steady
        tick(2);
        in_key[0] = 1'b1;
        tick(2);
        in_key[0] = 1'b0;
        tick(1);
        in_key[0] = 1'b1;
        tick(2);
        chk("s3_glitch", out_glitch, 4'h1);
        chk("s3_key_hold", out_key, 4'h1);
        tick(4);
        chk("s3_key_k8", out_key, 4'h1);
        chk("s3_rel_k8", out_release, 4'h0);
        tick(1);
        chk("s3_key_k9", out_key, 4'h0);
        chk("s3_rel_k9", out_release, 4'h1);
        tick(3);

        // Press bounce: low 3, high 1, low steady
        in_key[0] = 1'b0;
        tick(3);
        in_key[0] = 1'b1;
        tick(1);
        in_key[0] = 1'b0;
        tick(2);
        chk("s2_glitch", out_glitch, 4'h1);
        chk("s2_key_low", out_key, 4'h0);
        tick(4);
        chk("s2_key_k9", out_key, 4'h0);
        tick(1);
        chk("s2_key_k10", out_key, 4'h1);
        chk("s2_press_k10", out_press, 4'h1);
        in_key[0] = 1'b1;
        tick(10);
        chk("s2_released", out_key, 4'h0);

        // All lanes together
        in_key = 4'h0;
        tick(6);
        chk("s4_press_k5", out_press, 4'h0);
        tick(1);
        chk("s4_press_k6", out_press, 4'hF);
        chk("s4_key_k6", out_key, 4'hF);
        tick(1);
        chk("s4_press_k7", out_press, 4'h0);
        in_key = 4'hF;
        tick(6);
        chk("s4_rel_k5", out_release, 4'h0);
        tick(1);
        chk("s4_rel_k6", out_release, 4'hF);
        chk("s4_key_rel", out_key, 4'h0);
        tick(1);
        chk("s4_rel_k7", out_release, 4'h0);
        tick(2);

        // Reset in the middle of a press check, with lane 2 already pressed
        in_key[2] = 1'b0;
        tick(8);
        chk("s5_pre_key", out_key, 4'h4);
        in_key[0] = 1'b0;
        tick(5);
        rst_n = 1'b0;
        #2;
        chk("s5_rst_key", out_key, 4'h0);
        chk("s5_rst_pulses", {out_press, out_release, out_glitch}, 12'h000);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("s5_press_j5", out_press, 4'h0);
        chk("s5_key_j5", out_key, 4'h0);
        tick(1);
        chk("s5_press_j6", out_press, 4'h5);
        chk("s5_key_j6", out_key, 4'h5);
        in_key = 4'hF;
        tick(10);
        chk("s5_released", out_key, 4'h0);

        // Active-high polarity
        in_p[0] = 1'b1;
        tick(6);
        chk("s6_key_k5", key_p, 4'h0);
        tick(1);
        chk("s6_key_k6", key_p, 4'h1);
        chk("s6_press_k6", press_p, 4'h1);
        tick(1);
        chk("s6_press_k7", press_p, 4'h0);
        tick(2);

        chk("cnt_press", n_press, 9);
        chk("cnt_release", n_release, 8);
        chk("cnt_glitch", n_glitch, 2);
        chk("cnt_press_p0", n_press_p0, 1);
        chk("cnt_idle_lanes_p", n_pulse_p_other, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
